// File: rtl/imm_gen_pipe_pkg.sv
// Shared constants for the ID-stage immediate generator: opcodes, funct3
// shift encodings and the immediate format codes reported on out_fmt.
package imm_gen_pipe_pkg;

  // Major opcodes (inst[6:0]) that carry or imply an immediate format
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  // funct3 values that turn OP-IMM / OP-IMM-32 into shift-by-immediate
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SRX = 3'b101;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_R    = 3'd1,
    FMT_I    = 3'd2,
    FMT_S    = 3'd3,
    FMT_B    = 3'd4,
    FMT_U    = 3'd5,
    FMT_J    = 3'd6,
    FMT_SH   = 3'd7
  } fmt_e;

  // All eight 3-bit codes are taken, so the CSR zimm shares the code of the
  // other zero-extended small-field class (shift amount); the opcode tells
  // the two apart downstream.
  localparam fmt_e FMT_Z = FMT_SH;

endpackage

// File: rtl/imm_decode.sv
// Purely combinational RV32I/RV64I immediate decoder: inst -> imm/fmt/illegal.
module imm_decode
  import imm_gen_pipe_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = (XLEN == 64) ? 6 : 5
) (
  input  logic [31:0]     inst,
  output logic [XLEN-1:0] imm,
  output fmt_e            fmt,
  output logic            illegal
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh, imm_shw, imm_z;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];

  // Signed size casts replicate inst[31] up to bit XLEN-1
  assign imm_i   = XLEN'($signed(inst[31:20]));
  assign imm_s   = XLEN'($signed({inst[31:25], inst[11:7]}));
  assign imm_b   = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
  assign imm_u   = XLEN'($signed({inst[31:12], 12'b0}));
  assign imm_j   = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
  assign imm_sh  = XLEN'(inst[20 +: SHAMT_W]);
  assign imm_shw = XLEN'(inst[24:20]);
  assign imm_z   = XLEN'(inst[19:15]);

  // Select the immediate and format class from the opcode (and funct3 where it matters)
  always_comb begin
    imm     = '0;
    fmt     = FMT_NONE;
    illegal = 1'b0;
    case (opcode)
      OPC_OP, OPC_OP_32: fmt = FMT_R;
      OPC_LOAD, OPC_JALR: begin
        imm = imm_i;
        fmt = FMT_I;
      end
      OPC_OP_IMM: begin
        if (funct3 == F3_SLL || funct3 == F3_SRX) begin
          imm = imm_sh;
          fmt = FMT_SH;
        end else begin
          imm = imm_i;
          fmt = FMT_I;
        end
      end
      OPC_OP_IMM_32: begin
        if (XLEN == 64) begin
          if (funct3 == F3_SLL || funct3 == F3_SRX) begin
            imm = imm_shw;
            fmt = FMT_SH;
          end else begin
            imm = imm_i;
            fmt = FMT_I;
          end
        end else begin
          illegal = 1'b1;
        end
      end
      OPC_STORE: begin
        imm = imm_s;
        fmt = FMT_S;
      end
      OPC_BRANCH: begin
        imm = imm_b;
        fmt = FMT_B;
      end
      OPC_LUI, OPC_AUIPC: begin
        imm = imm_u;
        fmt = FMT_U;
      end
      OPC_JAL: begin
        imm = imm_j;
        fmt = FMT_J;
      end
      OPC_SYSTEM: begin
        if (funct3[2]) begin
          imm = imm_z;
          fmt = FMT_Z;
        end else begin
          imm = imm_i;
          fmt = FMT_I;
        end
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator: imm_decode behind a valid/ready output
// stage with a one-entry skid buffer and synchronous flush.
module imm_gen_pipe
  import imm_gen_pipe_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = (XLEN == 64) ? 6 : 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output fmt_e            out_fmt,
  output logic            out_illegal
);

  logic [XLEN-1:0] dec_imm;
  fmt_e            dec_fmt;
  logic            dec_illegal;

  logic            main_valid_q, main_valid_d;
  logic [XLEN-1:0] main_imm_q, main_imm_d;
  fmt_e            main_fmt_q, main_fmt_d;
  logic            main_ill_q, main_ill_d;
  logic            skid_valid_q, skid_valid_d;
  logic [XLEN-1:0] skid_imm_q, skid_imm_d;
  fmt_e            skid_fmt_q, skid_fmt_d;
  logic            skid_ill_q, skid_ill_d;

  logic accept;
  logic main_free;

  imm_decode #(.XLEN(XLEN), .SHAMT_W(SHAMT_W)) u_decode (
    .inst    (in_inst),
    .imm     (dec_imm),
    .fmt     (dec_fmt),
    .illegal (dec_illegal)
  );

  // A full skid register is the only thing that stops intake, so a stalled
  // main register can still absorb one more item without losing it.
  assign in_ready  = !rst && !flush && !skid_valid_q;
  assign accept    = in_valid && in_ready;
  assign main_free = !main_valid_q || out_ready;

  assign out_valid   = main_valid_q;
  assign out_imm     = main_imm_q;
  assign out_fmt     = main_fmt_q;
  assign out_illegal = main_ill_q;

  // Next-state for main/skid: flush empties both, otherwise refill main from
  // skid first (FIFO order), then from the decoder; park in skid when stalled.
  always_comb begin
    main_valid_d = main_valid_q;
    main_imm_d   = main_imm_q;
    main_fmt_d   = main_fmt_q;
    main_ill_d   = main_ill_q;
    skid_valid_d = skid_valid_q;
    skid_imm_d   = skid_imm_q;
    skid_fmt_d   = skid_fmt_q;
    skid_ill_d   = skid_ill_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (main_free) begin
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_imm_d   = skid_imm_q;
        main_fmt_d   = skid_fmt_q;
        main_ill_d   = skid_ill_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_valid_d = 1'b1;
        main_imm_d   = dec_imm;
        main_fmt_d   = dec_fmt;
        main_ill_d   = dec_illegal;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_imm_d   = dec_imm;
      skid_fmt_d   = dec_fmt;
      skid_ill_d   = dec_illegal;
    end
  end

  // State registers with synchronous reset to the idle, empty state
  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      main_imm_q   <= '0;
      main_fmt_q   <= FMT_NONE;
      main_ill_q   <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_imm_q   <= '0;
      skid_fmt_q   <= FMT_NONE;
      skid_ill_q   <= 1'b0;
    end else begin
      main_valid_q <= main_valid_d;
      main_imm_q   <= main_imm_d;
      main_fmt_q   <= main_fmt_d;
      main_ill_q   <= main_ill_d;
      skid_valid_q <= skid_valid_d;
      skid_imm_q   <= skid_imm_d;
      skid_fmt_q   <= skid_fmt_d;
      skid_ill_q   <= skid_ill_d;
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances driven in lockstep,
// checked against an arithmetic reference decoder and an in-order item queue.
module tb_imm_gen_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [31:0] in_inst = '0;

  logic        in_ready32, out_valid32, ill32;
  logic [31:0] imm32;
  logic [2:0]  fmt32;
  logic        in_ready64, out_valid64, ill64;
  logic [63:0] imm64;
  logic [2:0]  fmt64;

  int checks = 0;
  int errors = 0;
  logic [31:0] q[$];
  logic [6:0]  ops [12] = '{7'h03, 7'h13, 7'h1B, 7'h23, 7'h33, 7'h37,
                            7'h17, 7'h3B, 7'h63, 7'h67, 7'h6F, 7'h73};

  imm_gen_pipe #(.XLEN(32)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
    .in_inst(in_inst), .out_valid(out_valid32), .out_ready(out_ready),
    .out_imm(imm32), .out_fmt(fmt32), .out_illegal(ill32)
  );

  imm_gen_pipe #(.XLEN(64)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .in_inst(in_inst), .out_valid(out_valid64), .out_ready(out_ready),
    .out_imm(imm64), .out_fmt(fmt64), .out_illegal(ill64)
  );

  function automatic longint sx(input longint v, input int bits);
    longint half = longint'(1) << (bits - 1);
    return (v >= half) ? v - (half * 2) : v;
  endfunction

  // Reference: value of each immediate as a plain integer built from fields
  function automatic void ref_dec(input logic [31:0] inst, input int xlen,
                                  output logic [63:0] imm, output logic [2:0] fmt,
                                  output logic ill);
    longint w  = longint'(inst);
    longint op = w % 128;
    longint f3 = (w >> 12) % 8;
    longint b31 = (w >> 31) % 2;
    longint v  = 0;
    fmt = 3'd0;
    ill = 1'b0;
    case (op)
      'h33, 'h3B: fmt = 3'd1;
      'h03, 'h67: begin v = sx(w >> 20, 12); fmt = 3'd2; end
      'h13: begin
        if (f3 == 1 || f3 == 5) begin v = (w >> 20) % xlen; fmt = 3'd7; end
        else begin v = sx(w >> 20, 12); fmt = 3'd2; end
      end
      'h1B: begin
        if (xlen == 32) ill = 1'b1;
        else if (f3 == 1 || f3 == 5) begin v = (w >> 20) % 32; fmt = 3'd7; end
        else begin v = sx(w >> 20, 12); fmt = 3'd2; end
      end
      'h23: begin v = sx((w >> 25) * 32 + (w >> 7) % 32, 12); fmt = 3'd3; end
      'h63: begin
        v = sx(b31 * 4096 + ((w >> 7) % 2) * 2048 + ((w >> 25) % 64) * 32 + ((w >> 8) % 16) * 2, 13);
        fmt = 3'd4;
      end
      'h37, 'h17: begin v = sx((w >> 12) * 4096, 32); fmt = 3'd5; end
      'h6F: begin
        v = sx(b31 * 1048576 + ((w >> 12) % 256) * 4096 + ((w >> 20) % 2) * 2048 + ((w >> 21) % 1024) * 2, 21);
        fmt = 3'd6;
      end
      'h73: begin
        if (f3 >= 4) begin v = (w >> 15) % 32; fmt = 3'd7; end
        else begin v = sx(w >> 20, 12); fmt = 3'd2; end
      end
      default: ill = 1'b1;
    endcase
    imm = 64'(v);
    if (xlen == 32) imm[63:32] = '0;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock of stimulus, with model update and checks around the edge
  task automatic tick(input logic r, input logic f, input logic v,
                      input logic [31:0] inst, input logic rdy);
    logic        exp_rdy;
    logic [63:0] ei;
    logic [2:0]  ef;
    logic        el;
    rst = r; flush = f; in_valid = v; in_inst = inst; out_ready = rdy;
    #1;
    exp_rdy = !r && !f && (q.size() < 2);
    chk("in_ready32", 64'(in_ready32), 64'(exp_rdy));
    chk("in_ready64", 64'(in_ready64), 64'(exp_rdy));
    @(posedge clk);
    if (r) begin
      q.delete();
    end else begin
      if (q.size() > 0 && rdy) begin
        $display("xfer inst=%08h", q[0]);
        void'(q.pop_front());
      end
      if (f) q.delete();
      else if (v && exp_rdy) q.push_back(inst);
    end
    #1;
    chk("out_valid32", 64'(out_valid32), 64'(q.size() > 0));
    chk("out_valid64", 64'(out_valid64), 64'(q.size() > 0));
    if (q.size() > 0) begin
      ref_dec(q[0], 32, ei, ef, el);
      chk("imm32", 64'(imm32), ei);
      chk("fmt32", 64'(fmt32), 64'(ef));
      chk("ill32", 64'(ill32), 64'(el));
      ref_dec(q[0], 64, ei, ef, el);
      chk("imm64", imm64, ei);
      chk("fmt64", 64'(fmt64), 64'(ef));
      chk("ill64", 64'(ill64), 64'(el));
    end else if (r) begin
      chk("rst_imm32", 64'(imm32), 64'd0);
      chk("rst_fmt32", 64'(fmt32), 64'd0);
      chk("rst_ill32", 64'(ill32), 64'd0);
      chk("rst_imm64", imm64, 64'd0);
      chk("rst_fmt64", 64'(fmt64), 64'd0);
      chk("rst_ill64", 64'(ill64), 64'd0);
    end
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] x = $urandom;
    if ($urandom_range(0, 7) != 0) x[6:0] = ops[$urandom_range(0, 11)];
    return x;
  endfunction

  initial begin
    // Reset with handshakes offered
    tick(1, 0, 1, 32'hFFF00093, 1);
    tick(1, 0, 1, 32'hFFF00093, 1);

    // Directed decode vectors, out_ready=1
    tick(0, 0, 1, 32'hFFF00093, 1);
    tick(0, 0, 1, 32'hFE20AE23, 1);
    tick(0, 0, 1, 32'hFE000CE3, 1);
    tick(0, 0, 1, 32'h123452B7, 1);
    tick(0, 0, 1, 32'h001000EF, 1);
    tick(0, 0, 1, 32'h00309093, 1);
    tick(0, 0, 1, 32'h00000007, 1);
    tick(0, 0, 1, 32'h02109093, 1);
    tick(0, 0, 1, 32'h0000001B, 1);
    tick(0, 0, 1, 32'h0020D01B, 1);
    tick(0, 0, 1, 32'h3400D073, 1);
    tick(0, 0, 0, 32'h0, 1);

    // Back-pressure: third offer blocked until the skid frees
    tick(0, 0, 1, 32'h00100093, 0);
    tick(0, 0, 1, 32'h00200113, 0);
    tick(0, 0, 1, 32'h00300193, 0);
    tick(0, 0, 1, 32'h00300193, 0);
    tick(0, 0, 1, 32'h00300193, 1);
    tick(0, 0, 1, 32'h00300193, 1);
    tick(0, 0, 0, 32'h0, 1);
    tick(0, 0, 0, 32'h0, 1);

    // Flush with main and skid full and an offer in the same cycle
    tick(0, 0, 1, 32'h00400213, 0);
    tick(0, 0, 1, 32'h00500293, 0);
    tick(0, 1, 1, 32'h00600313, 1);
    tick(0, 0, 1, 32'h00700393, 1);
    tick(0, 0, 0, 32'h0, 1);

    // Reset mid-transfer with both entries full
    tick(0, 0, 1, 32'hFFF00093, 0);
    tick(0, 0, 1, 32'hFE20AE23, 0);
    tick(1, 0, 1, 32'hFE000CE3, 1);
    tick(0, 0, 0, 32'h0, 1);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      tick(($urandom_range(0, 59) == 0), ($urandom_range(0, 24) == 0),
           ($urandom_range(0, 3) != 0), rand_inst(), ($urandom_range(0, 2) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
